stack_sequencer: RTL
====================

// Module: stack_sequencer
// PURPOSE
//  Multi-cycle initiator for the memory stage's stack interface. Turns one-cycle CALL/RET/INT/RTI
//  requests from decode into ordered push/pop/read/write cycles on SP-addressed memory.
//  Drives the redirect strobes (interrupt, pc_choose_memory) and restores flags on RTI.
//  Sits between control unit and memory stage; stalls the front end while busy.
// PARAMETERS
//  STACK_DEPTH  1024  words of stack; bound for occupancy checks
//  PC_WIDTH     32    PC width; pushed as two 16-bit halves
//  FLAG_WIDTH   3     flag bits saved/restored
// PORTS
//  clk                  in   1   clock, rising edge
//  reset                in   1   asynchronous, active-low reset
//  req_call             in   1   push PC (hi, lo)
//  req_ret              in   1   pop PC, redirect from shift register
//  req_int              in   1   push PC + flags, redirect to vector 0
//  req_rti              in   1   pop flags + PC, redirect
//  mem_data             in   16  memory stage read data
//  memory_read          out  1   to memory stage
//  memory_write         out  1   to memory stage
//  memory_push          out  1   SP decrement
//  memory_pop           out  1   SP increment
//  memory_address_select    out  2   2'b10 (SP) while busy, else 2'b00
//  memory_write_src_select  out  2   00 flags, 01 PC hi, 10 PC lo
//  pc_choose_memory     out  1   redirect PC from memory shift register
//  interrupt            out  1   redirect PC to 0
//  flags_restore        out  3   flags popped by RTI
//  flags_restore_valid  out  1   one-cycle strobe with flags_restore
//  busy                 out  1   sequence in progress
//  stall                out  1   busy | any req accepted this cycle
//  done                 out  1   one-cycle strobe, last cycle of a sequence
//  stack_fault          out  1   sticky overflow/underflow flag
// BEHAVIOUR
//  - Reset (async, reset==0): state IDLE, all outputs 0, occupancy 0, int_pending 0, fault 0.
//    Reset mid-sequence aborts immediately; no partial op is completed.
//  - Moore outputs decoded from state. Requests sampled only in IDLE at the rising edge.
//    The first memory cycle follows in the next cycle. Each memory op is one cycle.
//  - Priority when simultaneous: INT > RTI > RET > CALL. Lower-priority requests are dropped.
//    The issuer holds stall-visible requests until accepted.
//  - req_int while busy sets int_pending. It is serviced on the cycle after done and cleared on acceptance.
//  - States and sequences (write_src / read):
//    CALL: PUSH_HI(01) -> PUSH_LO(10) -> IDLE. done on PUSH_LO. 2 cycles.
//    INT:  PUSH_HI -> PUSH_LO -> PUSH_FL(00) -> REDIRECT(interrupt=1) -> IDLE. 4 cycles.
//    RET:  POP_LO -> POP_HI -> REDIRECT(pc_choose_memory=1) -> IDLE. 3 cycles.
//    RTI:  POP_FL -> POP_LO -> POP_HI -> REDIRECT(pc_choose_memory=1) -> IDLE. 4 cycles.
//  - PUSH_* cycles: memory_write=1 and memory_push=1. POP_* cycles: memory_read=1 and memory_pop=1.
//    POP_FL goes first so the shift register ends as {hi, lo} at REDIRECT.
//  - POP_FL captures mem_data[2:0] into flags_restore at the end of the cycle.
//    flags_restore_valid pulses the next cycle.
//  - done is asserted in REDIRECT for INT/RET/RTI and in PUSH_LO for CALL.
//  - Occupancy counter: +1 per push cycle, -1 per pop cycle, range 0..STACK_DEPTH.
//    Checked at acceptance: pushes need occ+N <= STACK_DEPTH; pops need occ >= N.
//    On violation, the request is dropped, stack_fault is set (sticky until reset), and there is no done.
//  - No wrap-around: the counter saturates and is never driven past its bounds.
// STRUCTURE
//  stack_seq_pkg: state_t enum; WSRC_FLAGS=2'b00, WSRC_PC_HI=2'b01, WSRC_PC_LO=2'b10;
//    ADDR_SEL_SP=2'b10; op_t {OP_CALL, OP_RET, OP_INT, OP_RTI}; per-op push/pop counts.
//  Sub-module stack_occupancy_counter: up/down counter with check_push(N) and check_pop(N) outputs.
// TESTING
//  1. reset low mid-INT (in PUSH_LO) -> next edge: IDLE, all outputs 0, busy=0, occ=0.
//  2. req_call 1 cycle from reset -> PUSH_HI (wsrc=01), then PUSH_LO (wsrc=10, done=1); occ=2; busy 2 cycles.
//  3. INT then RTI with flags=3'b101, PC=0x0001_2345.
//     -> RTI pops 0x0005, 0x2345, 0x0001; flags_restore=3'b101; shift reg=0x00012345 at REDIRECT.
//  4. req_ret and req_call same cycle -> RET only (POP_LO, POP_HI, REDIRECT), CALL dropped.
//  5. req_int during RET POP_HI -> int_pending=1; INT PUSH_HI starts 1 cycle after RET done.
//  6. req_ret with occ=0 -> no memory ops, stack_fault=1 and stays 1.
//     With occ=1023, req_int -> fault; occ unchanged.

Source files
------------

// File: rtl/stack_seq_pkg.sv
// Shared types and encodings for the stack sequencer: FSM states, request opcodes,
// memory write-source selects and per-op stack word counts.
package stack_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPushHi,
    StPushLo,
    StPushFl,
    StPopFl,
    StPopLo,
    StPopHi,
    StRedirect
  } state_t;

  typedef enum logic [1:0] {OP_CALL, OP_RET, OP_INT, OP_RTI} op_t;

  localparam logic [1:0] WSRC_FLAGS  = 2'b00;
  localparam logic [1:0] WSRC_PC_HI  = 2'b01;
  localparam logic [1:0] WSRC_PC_LO  = 2'b10;
  localparam logic [1:0] ADDR_SEL_SP = 2'b10;

  function automatic logic is_push_op(input op_t op);
    return (op == OP_CALL) || (op == OP_INT);
  endfunction

  function automatic logic [1:0] push_count(input op_t op);
    case (op)
      OP_CALL: return 2'd2;
      OP_INT:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] pop_count(input op_t op);
    case (op)
      OP_RET:  return 2'd2;
      OP_RTI:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/stack_occupancy_counter.sv
// Saturating stack occupancy counter with admission checks for an N-word push or pop.
module stack_occupancy_counter #(
  parameter int unsigned STACK_DEPTH = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  input  logic [1:0] need_push,
  input  logic [1:0] need_pop,
  output logic       push_ok,
  output logic       pop_ok
);

  localparam int unsigned OccW = $clog2(STACK_DEPTH + 1);

  logic [OccW-1:0] occ_q, occ_d;

  always_comb begin
    occ_d = occ_q;
    if (inc && !dec && (32'(occ_q) < STACK_DEPTH)) begin
      occ_d = occ_q + 1'b1;
    end else if (dec && !inc && (occ_q != '0)) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign push_ok = (32'(occ_q) + 32'(need_push)) <= STACK_DEPTH;
  assign pop_ok  = 32'(occ_q) >= 32'(need_pop);

endmodule

// File: rtl/stack_sequencer.sv
// Multi-cycle CALL/RET/INT/RTI sequencer driving SP-addressed push/pop cycles on the
// memory stage, PC redirect strobes and flag restore; stalls the front end while busy.
module stack_sequencer
  import stack_seq_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 1024,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned FLAG_WIDTH  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_call,
  input  logic                    req_ret,
  input  logic                    req_int,
  input  logic                    req_rti,
  input  logic [PC_WIDTH/2-1:0]   mem_data,
  output logic                    memory_read,
  output logic                    memory_write,
  output logic                    memory_push,
  output logic                    memory_pop,
  output logic [1:0]              memory_address_select,
  output logic [1:0]              memory_write_src_select,
  output logic                    pc_choose_memory,
  output logic                    interrupt,
  output logic [FLAG_WIDTH-1:0]   flags_restore,
  output logic                    flags_restore_valid,
  output logic                    busy,
  output logic                    stall,
  output logic                    done,
  output logic                    stack_fault
);

  state_t                state_q, state_d;
  op_t                   op_q, op_d, op_sel;
  logic                  int_pending_q, int_pending_d;
  logic                  fault_q;
  logic [FLAG_WIDTH-1:0] flags_q;
  logic                  flags_valid_q;
  logic                  want_int, req_any, idle, admit_ok, start, reject;
  logic                  push_ok, pop_ok;

  // A pending interrupt competes exactly like a fresh req_int.
  assign want_int = req_int | int_pending_q;
  assign req_any  = want_int | req_rti | req_ret | req_call;
  assign idle     = (state_q == StIdle);

  always_comb begin
    if (want_int)     op_sel = OP_INT;
    else if (req_rti) op_sel = OP_RTI;
    else if (req_ret) op_sel = OP_RET;
    else              op_sel = OP_CALL;
  end

  assign admit_ok = is_push_op(op_sel) ? push_ok : pop_ok;
  assign start    = idle & req_any & admit_ok;
  assign reject   = idle & req_any & ~admit_ok;

  stack_occupancy_counter #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_occ (
    .clk      (clk),
    .reset    (reset),
    .inc      (memory_push),
    .dec      (memory_pop),
    .need_push(push_count(op_sel)),
    .need_pop (pop_count(op_sel)),
    .push_ok  (push_ok),
    .pop_ok   (pop_ok)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    int_pending_d = int_pending_q;
    if (start) op_d = op_sel;
    if ((start || reject) && (op_sel == OP_INT)) begin
      int_pending_d = 1'b0;
    end else if (!idle && req_int) begin
      int_pending_d = 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (is_push_op(op_sel))      state_d = StPushHi;
          else if (op_sel == OP_RTI)   state_d = StPopFl;
          else                         state_d = StPopLo;
        end
      end
      StPushHi:   state_d = StPushLo;
      StPushLo:   state_d = (op_q == OP_INT) ? StPushFl : StIdle;
      StPushFl:   state_d = StRedirect;
      StPopFl:    state_d = StPopLo;
      StPopLo:    state_d = StPopHi;
      StPopHi:    state_d = StRedirect;
      StRedirect: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    memory_read             = 1'b0;
    memory_write            = 1'b0;
    memory_push             = 1'b0;
    memory_pop              = 1'b0;
    memory_write_src_select = WSRC_FLAGS;
    pc_choose_memory        = 1'b0;
    interrupt               = 1'b0;
    done                    = 1'b0;
    unique case (state_q)
      StIdle: ;
      StPushHi: begin
        memory_write            = 1'b1;
        memory_push             = 1'b1;
        memory_write_src_select = WSRC_PC_HI;
      end
      StPushLo: begin
        memory_write            = 1'b1;
        memory_push             = 1'b1;
        memory_write_src_select = WSRC_PC_LO;
        done                    = (op_q == OP_CALL);
      end
      StPushFl: begin
        memory_write            = 1'b1;
        memory_push             = 1'b1;
        memory_write_src_select = WSRC_FLAGS;
      end
      StPopFl, StPopLo, StPopHi: begin
        memory_read = 1'b1;
        memory_pop  = 1'b1;
      end
      StRedirect: begin
        done             = 1'b1;
        interrupt        = (op_q == OP_INT);
        pc_choose_memory = (op_q != OP_INT);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      op_q          <= OP_CALL;
      int_pending_q <= 1'b0;
      fault_q       <= 1'b0;
      flags_q       <= '0;
      flags_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      int_pending_q <= int_pending_d;
      fault_q       <= fault_q | reject;
      flags_valid_q <= (state_q == StPopFl);
      if (state_q == StPopFl) flags_q <= mem_data[FLAG_WIDTH-1:0];
    end
  end

  logic unused_mem_data;
  assign unused_mem_data = ^mem_data[PC_WIDTH/2-1:FLAG_WIDTH];

  assign busy                  = ~idle;
  assign stall                 = busy | start;
  assign memory_address_select = busy ? ADDR_SEL_SP : 2'b00;
  assign flags_restore         = flags_q;
  assign flags_restore_valid   = flags_valid_q;
  assign stack_fault           = fault_q;

endmodule
